// File: rtl/pipeline_result_accum.sv
// Frame accumulator for the dot-product result stream.
// Sums FRAME_LEN beats with saturation and emits a registered total.
module pipeline_result_accum #(
  parameter int DATA_W    = 20,
  parameter int ACC_W     = 24,
  parameter int FRAME_LEN = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  input  logic              flush_i,
  output logic              valid_o,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o,
  input  logic              ready_i
);

  localparam int CNT_W =
    (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(FRAME_LEN - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic             valid_d;
  logic [ACC_W-1:0] sum_d;
  logic             ovf_d;

  logic             last_beat;
  logic             in_fire;
  logic             out_fire;
  logic [ACC_W:0]   sum_wide;
  logic             over;
  logic [ACC_W-1:0] sum_sat;

  assign last_beat = (cnt_q == LAST);
  assign ready_o   = !flush_i &
                     (!last_beat | !valid_o | ready_i);
  assign in_fire   = valid_i & ready_o;
  assign out_fire  = valid_o & ready_i;

  // Saturating add one bit wider than the accumulator
  always_comb begin
    sum_wide = {1'b0, acc_q} + (ACC_W+1)'(data_i);
    over     = sum_wide[ACC_W];
    sum_sat  = over ? {ACC_W{1'b1}}
                    : sum_wide[ACC_W-1:0];
  end

  // Frame progress: accumulate, close the frame, or flush
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (flush_i) begin
      acc_d    = '0;
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (in_fire) begin
      if (last_beat) begin
        acc_d    = '0;
        cnt_d    = '0;
        sticky_d = 1'b0;
      end else begin
        acc_d    = sum_sat;
        cnt_d    = cnt_q + CNT_W'(1);
        sticky_d = sticky_q | over;
      end
    end
  end

  // Output register: load on final beat, drop on drain
  always_comb begin
    valid_d = valid_o;
    sum_d   = sum_o;
    ovf_d   = ovf_o;
    if (in_fire && last_beat) begin
      valid_d = 1'b1;
      sum_d   = sum_sat;
      ovf_d   = sticky_q | over;
    end else if (out_fire) begin
      valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      valid_o  <= 1'b0;
      sum_o    <= '0;
      ovf_o    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      valid_o  <= valid_d;
      sum_o    <= sum_d;
      ovf_o    <= ovf_d;
    end
  end

endmodule
